// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stall-vector encodings, MDU state type and pipeline timing defaults
package pipe_pkg;
  localparam int STALL_PC    = 0;
  localparam int STALL_IFID  = 1;
  localparam int STALL_IDEX  = 2;
  localparam int STALL_EXMEM = 3;
  localparam int STALL_WB    = 4;
  localparam logic [4:0] STALL_NONE = 5'h00;
  localparam logic [4:0] STALL_ID   = 5'h03;
  localparam logic [4:0] STALL_EX   = 5'h07;
  localparam logic [4:0] STALL_MEM  = 5'h0F;
  localparam int MDU_LAT     = 34;
  localparam int MEM_TIMEOUT = 255;
  typedef enum logic {MDU_IDLE, MDU_BUSY} mdu_state_e;
endpackage

// File: rtl/pipe_mem_watchdog.sv
// pipe_mem_watchdog: counts consecutive MEM wait cycles and pulses bus_err on the TIMEOUT-th one
module pipe_mem_watchdog
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = MEM_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_wait,
  input  logic flush,
  output logic bus_err
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] wcnt_q, wcnt_d;
  logic hit;
  always_comb begin
    hit     = mem_wait && (wcnt_q == W'(TIMEOUT - 1));
    bus_err = hit && !flush && !rst;
    wcnt_d  = (flush || !mem_wait || hit) ? '0 : wcnt_q + W'(1);
  end
  always_ff @(posedge clk) wcnt_q <= rst ? '0 : wcnt_d;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with MDU sequencing and MEM bus watchdog
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_LAT     = pipe_pkg::MDU_LAT,
  parameter int MEM_TIMEOUT = pipe_pkg::MEM_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        mdu_start,
  input  logic        mem_req,
  input  logic        mem_ack,
  input  logic        flush_req,
  input  logic [31:0] flush_pc,
  output logic [4:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        mdu_busy,
  output logic        mdu_done,
  output logic        bus_err,
  output logic [31:0] stall_cycles
);
  localparam int CW = $clog2(MDU_LAT + 1);
  mdu_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic mem_wait, mdu_stall, last;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= MDU_IDLE;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
  // The final count holds while MEM waits so the result is not lost to a stalled EX.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stall_cycles_d = (stall != STALL_NONE) ? stall_cycles_q + 32'd1 : stall_cycles_q;
    if (flush_req) begin
      state_d = MDU_IDLE;
      cnt_d   = '0;
    end else if (state_q == MDU_IDLE && mdu_start) begin
      state_d = MDU_BUSY;
      cnt_d   = CW'(MDU_LAT);
    end else if (state_q == MDU_BUSY && !last) begin
      cnt_d = cnt_q - CW'(1);
    end else if (state_q == MDU_BUSY && !mem_wait) begin
      state_d = MDU_IDLE;
      cnt_d   = '0;
    end
  end
  always_comb begin
    mem_wait     = mem_req && !mem_ack;
    last         = cnt_q <= CW'(1);
    mdu_stall    = (state_q == MDU_IDLE) ? mdu_start : !last;
    flush        = !rst && flush_req;
    new_pc       = flush ? flush_pc : '0;
    stall        = (rst || flush_req) ? STALL_NONE :
                   mem_wait ? STALL_MEM :
                   (mdu_stall || stallreq_ex) ? STALL_EX :
                   stallreq_id ? STALL_ID : STALL_NONE;
    mdu_busy     = !rst && state_q == MDU_BUSY;
    mdu_done     = mdu_busy && !flush_req && last && !mem_wait;
    stall_cycles = rst ? '0 : stall_cycles_q;
  end
  pipe_mem_watchdog #(.TIMEOUT(MEM_TIMEOUT)) u_wd (
    .clk      (clk),
    .rst      (rst),
    .mem_wait (mem_wait),
    .flush    (flush_req),
    .bus_err  (bus_err)
  );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed literal checks plus randomized traffic against an elapsed-cycle model
module tb_pipe_ctrl;
  localparam int LAT = 4;
  localparam int TO  = 8;
  logic clk = 0, rst = 1, id = 0, ex = 0, start = 0, req = 0, ack = 0, fl = 0;
  logic [31:0] fpc = 0;
  logic [4:0] stall;
  logic flush, mdu_busy, mdu_done, bus_err;
  logic [31:0] new_pc, stall_cycles;
  always #5 clk = ~clk;
  pipe_ctrl #(.MDU_LAT(LAT), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .stallreq_id(id), .stallreq_ex(ex), .mdu_start(start),
    .mem_req(req), .mem_ack(ack), .flush_req(fl), .flush_pc(fpc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .mdu_busy(mdu_busy),
    .mdu_done(mdu_done), .bus_err(bus_err), .stall_cycles(stall_cycles)
  );
  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: MDU tracked as cycles elapsed since start, watchdog as length of current wait run
  bit m_act = 0;
  int m_el = 0, m_run = 0;
  logic [31:0] m_sc = 0;
  logic [4:0] e_stall;
  logic [31:0] e_pc, e_sc;
  logic e_fl, e_busy, e_done, e_err, w, ms;
  always @(negedge clk) begin
    w = req && !ack;
    if (rst) begin
      e_stall = 0; e_pc = 0; e_sc = 0; e_fl = 0; e_busy = 0; e_done = 0; e_err = 0;
    end else begin
      ms      = (!m_act && start) || (m_act && m_el < LAT);
      e_fl    = fl;
      e_pc    = fl ? fpc : 0;
      e_busy  = m_act;
      e_stall = fl ? 5'h00 : w ? 5'h0F : (ms || ex) ? 5'h07 : id ? 5'h03 : 5'h00;
      e_done  = !fl && m_act && m_el >= LAT && !w;
      e_err   = !fl && w && (m_run + 1 == TO);
      e_sc    = m_sc;
    end
    chk("m_stall", stall, e_stall);
    chk("m_flush", flush, e_fl);
    chk("m_new_pc", new_pc, e_pc);
    chk("m_busy", mdu_busy, e_busy);
    chk("m_done", mdu_done, e_done);
    chk("m_bus_err", bus_err, e_err);
    chk("m_stall_cycles", stall_cycles, e_sc);
    if (rst) begin
      m_act = 0; m_el = 0; m_run = 0; m_sc = 0;
    end else begin
      m_sc = m_sc + (e_stall != 0);
      if (fl) begin
        m_act = 0; m_run = 0;
      end else begin
        if (!m_act && start) begin m_act = 1; m_el = 1; end
        else if (m_act && m_el >= LAT && !w) m_act = 0;
        else if (m_act) m_el++;
        m_run = !w ? 0 : (m_run + 1 == TO) ? 0 : m_run + 1;
      end
    end
  end
  task automatic step(input bit r, i, e, s, q, a, f, input logic [31:0] pc = 0);
    @(posedge clk);
    #1;
    rst = r; id = i; ex = e; start = s; req = q; ack = a; fl = f; fpc = pc;
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic at_neg;
    @(negedge clk);
    #1;
  endtask
  function automatic bit p(input int k);
    return $urandom_range(0, 99) < k;
  endfunction
  initial begin
    step(1, 1, 1, 1, 1, 0, 0);
    at_neg; chk("rst_stall", stall, 5'h00); chk("rst_busy", mdu_busy, 0); chk("rst_sc", stall_cycles, 0);
    step(0, 1, 0, 0, 0, 0, 0); at_neg; chk("prio_id", stall, 5'h03);
    step(0, 1, 1, 0, 0, 0, 0); at_neg; chk("prio_ex", stall, 5'h07);
    step(0, 1, 1, 0, 1, 0, 0); at_neg; chk("prio_mem", stall, 5'h0F);
    step(0, 1, 1, 0, 1, 0, 1, 32'hBFC00380); at_neg;
    chk("prio_fl_stall", stall, 5'h00); chk("prio_fl", flush, 1);
    chk("prio_fl_pc", new_pc, 32'hBFC00380); chk("prio_sc", stall_cycles, 3);
    step(0, 0, 0, 1, 0, 0, 0); at_neg; chk("mdu_t0", stall, 5'h07); chk("mdu_t0_busy", mdu_busy, 0);
    idle(1); at_neg; chk("mdu_t1", stall, 5'h07); chk("mdu_t1_busy", mdu_busy, 1);
    step(0, 0, 0, 1, 0, 0, 0); at_neg; chk("mdu_t2", stall, 5'h07);
    idle(1); at_neg; chk("mdu_t3", stall, 5'h07);
    idle(1); at_neg; chk("mdu_t4_stall", stall, 5'h00); chk("mdu_t4_done", mdu_done, 1);
    idle(1); at_neg; chk("mdu_t5_busy", mdu_busy, 0); chk("mdu_t5_done", mdu_done, 0);
    step(0, 0, 0, 1, 0, 0, 0); idle(2);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 0, 0); at_neg; chk("mw_stall", stall, 5'h0F); chk("mw_done", mdu_done, 0);
    end
    idle(1); at_neg; chk("mw_done_late", mdu_done, 1); chk("mw_stall0", stall, 5'h00);
    idle(1); at_neg; chk("mw_idle", mdu_busy, 0);
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 0, 0, 1, 0, 0); at_neg; chk("wd_err", bus_err, (i % 8) == 0);
    end
    step(0, 0, 0, 0, 1, 1, 0); at_neg; chk("wd_ack_stall", stall, 5'h00); chk("wd_ack_err", bus_err, 0);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, 0, 1, 0, 0); at_neg; chk("wd_err2", bus_err, i == 8);
    end
    idle(1);
    step(0, 0, 0, 1, 0, 0, 0); idle(2);
    step(0, 0, 0, 0, 0, 0, 1, 32'h80000180); at_neg;
    chk("fa_flush", flush, 1); chk("fa_done", mdu_done, 0); chk("fa_stall", stall, 5'h00);
    idle(1); at_neg; chk("fa_busy", mdu_busy, 0); chk("fa_done1", mdu_done, 0);
    idle(1); at_neg; chk("fa_done2", mdu_done, 0);
    step(0, 0, 0, 1, 0, 0, 0); idle(2);
    step(1, 0, 0, 0, 0, 0, 0); at_neg;
    chk("ra_stall", stall, 0); chk("ra_busy", mdu_busy, 0); chk("ra_sc", stall_cycles, 0); chk("ra_done", mdu_done, 0);
    idle(1); at_neg; chk("ra_busy1", mdu_busy, 0); chk("ra_done1", mdu_done, 0); chk("ra_sc1", stall_cycles, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    #1 force dut.stall_cycles_q = 32'hFFFFFFFF;
    m_sc = 32'hFFFFFFFF;
    #1 release dut.stall_cycles_q;
    at_neg; chk("wrap_pre", stall_cycles, 32'hFFFFFFFF);
    idle(1); at_neg; chk("wrap_post", stall_cycles, 32'h0);
    for (int n = 0; n < 4000; n++) begin
      bool_step: begin
        bit lw;
        lw = n >= 2500;
        step(p(1), p(25), p(15), p(15), p(lw ? 90 : 40), p(lw ? 10 : 50), p(lw ? 1 : 3), $urandom);
      end
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. It collects stall requests from ID, EX and MEM, sequences multi-cycle multiply/divide operations, and watches the MEM data-bus handshake. It drives one hold vector to the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the exception/eret redirect. A stage register holds when its stall bit is 1; it loads a bubble when its own bit is 0 and the bit of the stage before it is 1.

## Interface
- MDU_LAT, 34: multiply/divide latency in cycles, counted from the start cycle. Must be ≥2.
- MEM_TIMEOUT, 255: maximum number of consecutive MEM wait cycles before a bus error is raised.
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- stallreq_id  in  1  load-use hazard from ID (combinational)
- stallreq_ex  in  1  generic EX stall request
- mdu_start  in  1  EX issues a multi-cycle mult/div
- mem_req  in  1  MEM stage data access is pending
- mem_ack  in  1  data bus completes the access this cycle
- flush_req  in  1  exception/eret pulse from MEM
- flush_pc  in  32  redirect target
- stall  out  5  hold vector: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB
- flush  out  1  clear all pipeline registers
- new_pc  out  32  redirect PC, valid when flush=1
- mdu_busy  out  1  MDU operation in flight
- mdu_done  out  1  one-cycle pulse; EX captures the MDU result
- bus_err  out  1  one-cycle pulse on MEM timeout
- stall_cycles  out  32  count of cycles with stall≠0; wraps

## Operation
- Stall vector priority, highest first:
  - flush: stall=5'h00
  - MEM wait, i.e. mem_req & !mem_ack: 5'h0F
  - MDU stall: 5'h07
  - stallreq_ex: 5'h07
  - stallreq_id: 5'h03
  - otherwise: 5'h00
- stall, flush and new_pc are combinational from the inputs and state. new_pc=flush_pc when flush=1, otherwise 0.
- MDU FSM, states IDLE and BUSY:
  - IDLE, mdu_start=1, flush_req=0: load cnt=MDU_LAT and go to BUSY. The MDU stall is asserted in this start cycle.
  - BUSY, cnt>1: decrement cnt; MDU stall=1; mdu_busy=1.
  - BUSY, cnt==1, no MEM wait: mdu_done=1, MDU stall=0, go to IDLE.
  - BUSY, cnt==1, MEM wait active: hold cnt at 1 and suppress mdu_done until the wait clears.
  - mdu_start while BUSY is ignored.
- Flush: flush_req=1 forces flush=1 and stall=0 in the same cycle. It sends the FSM to IDLE, clears cnt and the watchdog count, and suppresses mdu_done and bus_err.
- Watchdog:
  - wcnt increments each MEM-wait cycle and clears on any non-wait cycle.
  - When wcnt reaches MEM_TIMEOUT: bus_err=1 for one cycle and wcnt clears.
  - The stall continues until an ack arrives or a flush occurs.
- stall_cycles increments on every cycle with stall≠0, wrapping 32'hFFFFFFFF→0.

## Timing
- Reset values: FSM=IDLE, cnt=0, wcnt=0, stall_cycles=0.
- While rst=1, all outputs are 0, including the combinational ones.
- Reset asserted mid-MDU or mid-wait aborts the operation with no mdu_done.
- MDU timing: with the start in cycle T, stall=5'h07 in cycles T..T+MDU_LAT-1 and mdu_done=1 in cycle T+MDU_LAT. The MEM-wait extension above applies.
- mem_req and mem_ack high together give a zero-wait access: no stall, wcnt unchanged at 0.
- A flush coincident with mdu_start or mem_ack: flush wins.
- Stall and redirect are zero-latency; the registered state updates at the next clk edge.

## Structure
- Shared package pipe_pkg holds:
  - stall bit indices STALL_PC…STALL_WB;
  - masks STALL_NONE=5'h00, STALL_ID=5'h03, STALL_EX=5'h07, STALL_MEM=5'h0F;
  - the MDU state enum {MDU_IDLE, MDU_BUSY}.
- The same package holds these defaults, shared with the MDU: MDU_LAT and MEM_TIMEOUT.
- One sub-module, pipe_mem_watchdog, holds the wcnt counter and bus_err pulse. Everything else is flat in pipe_ctrl.

## Test plan
- Priority: stallreq_id=1 → stall=5'h03. Add stallreq_ex → 5'h07. Add mem_req=1, mem_ack=0 → 5'h0F. Add flush_req with flush_pc=32'hBFC00380 → stall=0, flush=1, new_pc=32'hBFC00380.
- MDU latency: MDU_LAT=4, mdu_start pulse at T → stall=5'h07 for T..T+3, mdu_done at T+4, mdu_busy low at T+5. A second mdu_start at T+2 is ignored.
- MDU completion during MEM wait: MEM wait from T+3 to T+6 → mdu_done is delayed to the first cycle after the wait clears; stall=5'h0F during the wait.
- Watchdog: MEM_TIMEOUT=8, mem_req=1, mem_ack=0 → bus_err pulses after 8 wait cycles, then again after 8 more. Asserting mem_ack clears wcnt.
- Flush/reset abort: flush_req at cnt=2 → no mdu_done, FSM idle next cycle. rst at cnt=2 → all outputs 0, stall_cycles=0.
- Counter wrap: preload stall_cycles to 32'hFFFFFFFF via force, one stalled cycle → 0.
